// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the four-requester round-robin arbiter:
//   N_REQ      - number of requesters (fixed at 4)
//   IDX_W      - width of a requester index
//   arbState_t - arbiter FSM states (ST_IDLE = 0, ST_BUSY = 1)
//   oneHot()   - index to one-hot grant vector
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arbState_t;

  function automatic logic [N_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// -----------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin pick: rotate the eligible requests so that
// requester ptr lands at bit 0, find the first set bit, then un-rotate.
// Ports:
//   req    [3:0] in   raw request vector
//   ptr    [1:0] in   highest-priority requester
//   mask   [3:0] in   requesters excluded from this pick
//   winner [1:0] out  picked requester (equals ptr when any=0)
//   any          out  at least one eligible requester
// -----------------------------------------------------------------------------
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [IDX_W-1:0] winner,
  output logic             any
);

  logic [N_REQ-1:0]   eligible;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   k;

  always_comb begin
    eligible = req & ~mask;
    // Shifting the doubled vector right implements rotate-right by ptr.
    doubled  = {eligible, eligible} >> ptr;
    rot      = doubled[N_REQ-1:0];

    // Scan top-down so the lowest set bit is the last one written.
    k = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) begin
        k = IDX_W'(i - 1);
      end
    end

    // 2-bit addition wraps naturally, undoing the rotation.
    winner = ptr + k;
    any    = |eligible;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Four-requester round-robin arbiter with registered one-hot grants held until
// the owner drops its request. A release with other requests pending hands the
// grant straight to the next winner without an idle cycle.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN): an owner that has held
// the grant for HOLD_MAX cycles is preempted when another requester is waiting.
// Without the macro HOLD_MAX is only range-checked and grants are held
// indefinitely.
//
// Parameters:
//   HOLD_MAX  maximum consecutive grant cycles before preemption (1..255)
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous active-high reset
//   req      [3:0] in  request vector
//   gnt      [3:0] out registered one-hot grant, zero when no owner
//   gntIdx   [1:0] out index of current owner, zero when gntValid=0
//   gntValid       out high while a grant is active
// -----------------------------------------------------------------------------
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gntIdx,
  output logic             gntValid
);

  if (HOLD_MAX == 0 || HOLD_MAX > 255) begin : gHoldRange
    $error("rr_arbiter4: HOLD_MAX must be in 1..255");
  end

  arbState_t        stateQ, stateD;
  logic [IDX_W-1:0] ptrQ, ptrD;
  logic [N_REQ-1:0] gntD;
  logic [IDX_W-1:0] gntIdxD;
  logic             gntValidD;
  logic             newGrant;

  logic [N_REQ-1:0] pickMask;
  logic [IDX_W-1:0] pickWinner;
  logic             pickAny;

  rr_pick4 uPick (
    .req    (req),
    .ptr    (ptrQ),
    .mask   (pickMask),
    .winner (pickWinner),
    .any    (pickAny)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  logic [7:0] holdCnt;
  logic       holdExpired;

  // holdCnt counts BUSY edges already completed; the upcoming edge is the
  // HOLD_MAX-th one once holdCnt reaches HOLD_MAX-1.
  assign holdExpired = (holdCnt >= HOLD_LIM - 8'd1);

  // While the owner still holds, mask it out so pickAny means "someone else
  // is waiting" and pickWinner is the preemption target.
  always_comb begin
    pickMask = '0;
    if (stateQ == ST_BUSY && req[gntIdx]) begin
      pickMask = oneHot(gntIdx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdCnt <= '0;
    end else if (newGrant || stateD == ST_IDLE) begin
      holdCnt <= '0;
    end else if (holdCnt < HOLD_LIM) begin
      holdCnt <= holdCnt + 8'd1;
    end
  end
`else
  assign pickMask = '0;
`endif

  always_comb begin
    stateD    = stateQ;
    ptrD      = ptrQ;
    gntD      = gnt;
    gntIdxD   = gntIdx;
    gntValidD = gntValid;
    newGrant  = 1'b0;

    case (stateQ)
      ST_IDLE: begin
        if (pickAny) begin
          newGrant = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!req[gntIdx]) begin
          if (pickAny) begin
            newGrant = 1'b1;
          end else begin
            stateD    = ST_IDLE;
            gntD      = '0;
            gntIdxD   = '0;
            gntValidD = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (holdExpired && pickAny) begin
          newGrant = 1'b1;
        end
`endif
      end
    endcase

    if (newGrant) begin
      stateD    = ST_BUSY;
      gntD      = oneHot(pickWinner);
      gntIdxD   = pickWinner;
      gntValidD = 1'b1;
      ptrD      = pickWinner + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ   <= ST_IDLE;
      ptrQ     <= '0;
      gnt      <= '0;
      gntIdx   <= '0;
      gntValid <= 1'b0;
    end else begin
      stateQ   <= stateD;
      ptrQ     <= ptrD;
      gnt      <= gntD;
      gntIdx   <= gntIdxD;
      gntValid <= gntValidD;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

  localparam int unsigned HOLD_MAX = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gntIdx;
  logic       gntValid;

  int tests = 0;
  int fails = 0;

  rr_arbiter4 #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .gntIdx   (gntIdx),
    .gntValid (gntValid)
  );

  always #5 clk = ~clk;

  // Behavioural model: owner (-1 = none), priority pointer, and the cycle
  // number at which the current grant was made.
  int mOwner      = -1;
  int mPtr        = 0;
  int cycle       = 0;
  int mGrantCycle = 0;
  int mNext;

  // First requesting index in cyclic order starting at p, skipping 'skip'.
  function automatic int pickModel(input logic [3:0] r, input int p, input int skip);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (p + i) % 4;
      if (r[c] && c != skip) return c;
    end
    return -1;
  endfunction

  function automatic int modelNext(input logic [3:0] r, input int owner,
                                   input int p, input int held);
    if (owner < 0) return pickModel(r, p, -1);
    if (!r[owner]) return pickModel(r, p, -1);
`ifdef ARB_TIMEOUT_EN
    if (held >= int'(HOLD_MAX)) begin
      int w;
      w = pickModel(r, p, owner);
      if (w >= 0) return w;
    end
`endif
    return owner;
  endfunction

  always_comb mNext = modelNext(req, mOwner, mPtr, cycle - mGrantCycle);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mOwner      <= -1;
      mPtr        <= 0;
      cycle       <= 0;
      mGrantCycle <= 0;
    end else begin
      cycle  <= cycle + 1;
      mOwner <= mNext;
      if (mNext >= 0 && mNext != mOwner) begin
        mPtr        <= (mNext + 1) % 4;
        mGrantCycle <= cycle;
      end
    end
  end

  task automatic compare(input string name, input logic [3:0] eg,
                         input logic [1:0] ei, input logic ev);
    tests++;
    if (gnt !== eg || gntIdx !== ei || gntValid !== ev) begin
      fails++;
      $display("FAIL %s @%0t: got gnt=%b gntIdx=%0d gntValid=%b, want gnt=%b gntIdx=%0d gntValid=%b",
               name, $time, gnt, gntIdx, gntValid, eg, ei, ev);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (mOwner < 0) compare("model", 4'b0000, 2'd0, 1'b0);
      else            compare("model", 4'b0001 << mOwner, 2'(mOwner), 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    repeat (2) @(negedge clk);
    compare("reset_hold", 4'b0000, 2'd0, 1'b0);
    reset = 1'b0;

    // Rotation: each owner holds two cycles then drops its bit.
    for (int i = 0; i < 5; i++) begin
      int e;
      logic [3:0] oh;
      e  = i % 4;
      oh = 4'b0001 << e;
      @(negedge clk);
      compare("rot_first", oh, 2'(e), 1'b1);
      req = 4'b1111;
      @(negedge clk);
      compare("rot_second", oh, 2'(e), 1'b1);
      req = 4'b1111 & ~oh;
    end
    @(negedge clk);
    compare("rot_after", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    repeat (2) @(negedge clk);
    compare("idle1", 4'b0000, 2'd0, 1'b0);

    // Skip and wrap: grant 2 (ptr -> 3), go idle, then 0110 picks 1.
    req = 4'b0100;
    @(negedge clk);
    compare("own2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    compare("idle2", 4'b0000, 2'd0, 1'b0);
    req = 4'b0110;
    @(negedge clk);
    compare("wrap_pick1", 4'b0010, 2'd1, 1'b1);
    req = 4'b0100;
    @(negedge clk);
    compare("release_to2", 4'b0100, 2'd2, 1'b1);
    req = 4'b0000;
    @(negedge clk);
    compare("back_idle", 4'b0000, 2'd0, 1'b0);

    // Async reset mid-grant with owner 2 (ptr = 3 before reset).
    req = 4'b0100;
    @(negedge clk);
    compare("own2_again", 4'b0100, 2'd2, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 compare("async_reset", 4'b0000, 2'd0, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    req = 4'b1111;
    @(negedge clk);
    compare("ptr_after_reset", 4'b0001, 2'd0, 1'b1);

    // Single requester held for 20 cycles.
    req = 4'b1000;
    repeat (20) begin
      @(negedge clk);
      compare("single3", 4'b1000, 2'd3, 1'b1);
    end

    // Long hold by 0 with 2 arriving at cycle 3.
    req = 4'b0000;
    @(negedge clk);
    compare("idle3", 4'b0000, 2'd0, 1'b0);
    req = 4'b0001;
    for (int k = 1; k <= 12; k++) begin
      logic [3:0] eg;
      logic [1:0] ei;
`ifdef ARB_TIMEOUT_EN
      eg = (k <= int'(HOLD_MAX)) ? 4'b0001 : 4'b0100;
      ei = (k <= int'(HOLD_MAX)) ? 2'd0 : 2'd2;
`else
      eg = 4'b0001;
      ei = 2'd0;
`endif
      @(negedge clk);
      compare("hold_timeout", eg, ei, 1'b1);
      if (k == 3) req = 4'b0101;
    end

    req = 4'b0000;
    repeat (3) @(negedge clk);
    compare("final_idle", 4'b0000, 2'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (e.g. a shared datapath port) among requesters 0..3.
- Uses a rotate-then-scan priority pick: requests are rotated so the round-robin pointer lands at bit 0, then scanned for the first set bit.
- Grants are registered, one-hot and held until the owner releases its request. This makes it the sequencing layer above the team's 4-bit bit-scan encoder.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4, other values unsupported.
- HOLD_MAX, 8, maximum consecutive grant cycles before preemption; used only with ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i]=1 means requester i wants the resource.
- gnt  output  4  registered one-hot grant; all zeros when no owner.
- gntIdx  output  2  binary index of the current owner; 0 when gntValid=0.
- gntValid  output  1  high while any grant is active (equals |gnt).

Behaviour:
- Reset (async, active-high):
  - Sets gnt=4'b0000, gntIdx=0, gntValid=0, ptr=0, state IDLE, hold counter=0.
  - Asserting reset mid-grant drops all outputs immediately, without waiting for a clock edge.
- State register: IDLE (no owner), BUSY (owner held in gntIdx). 2-bit pointer ptr marks the highest-priority requester.
- Pick function:
  - rot = req rotated right by ptr, so bit 0 of rot is requester ptr.
  - Take the first set bit k of rot, scanning from bit 0 upward.
  - winner = (ptr + k) mod 4, computed in 2-bit wrap-around arithmetic. No winner if req==0.
- IDLE:
  - req==0: stay in IDLE.
  - Otherwise, at the next edge: gnt=onehot(winner), gntIdx=winner, gntValid=1, ptr=winner+1 (mod 4), go to BUSY.
  - Latency: grant is visible one cycle after req is first sampled high.
- BUSY with req[gntIdx]=1: hold the grant unchanged. Other requests are ignored, apart from the timeout path.
- BUSY with req[gntIdx]=0 (release):
  - Another request pending: at the next edge, switch directly to the new winner picked from ptr, with no bubble cycle.
  - No other request: at the next edge, go to IDLE and clear gnt, gntIdx and gntValid.
- Simultaneous release and new request in the same cycle: the new request is considered by the same pick.
- ptr wraps 3 -> 0.
- gnt is never more than one-hot. A glitch-free registered output is required.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With ARB_TIMEOUT_EN:
  - An 8-bit hold counter clears on every new grant and increments each BUSY cycle.
  - When the counter reaches HOLD_MAX and any other requester is pending, the next edge preempts the owner. The grant moves to the pick over req with the owner's bit masked, and ptr advances past the new owner.
  - If no other requester is pending, the grant is kept and the counter saturates at HOLD_MAX.
- Without the macro: no counter is instantiated, grants are held indefinitely, and HOLD_MAX is ignored.

Decomposition:
- Shared package arb_pkg holds:
  - localparams N_REQ=4 and IDX_W=2.
  - State encodings ST_IDLE=1'b0 and ST_BUSY=1'b1.
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], ptr[1:0], mask[3:0].
  - Outputs: winner[1:0], any.
  - Contains the rotate, first-set-bit scan and un-rotate.
- The top level holds the FSM, ptr, output registers and the optional counter.

Test Plan:
- Reset with req=4'b1111 held: gnt=0000 and gntValid=0 during reset. On the first edge after reset deasserts, gnt=0001, gntIdx=0, and ptr becomes 1.
- Rotation: from reset, req=4'b1111 with each owner dropping its bit after 2 cycles and reasserting it afterwards. Grant sequence must be 0,1,2,3,0, with no idle cycle between owners.
- Skip and wrap:
  - ptr=3 and req=4'b0110: grant goes to 1.
  - Release requester 1 while req=4'b0100: grant goes to 2 on the next edge.
  - Then req=0: IDLE with gnt=0000.
- Async reset mid-grant: owner=2 in BUSY, reset pulses between clock edges. gnt=0000 and gntValid=0 before the next edge, and ptr=0.
- Single requester: req=4'b1000 held for 20 cycles. gnt=1000 and gntIdx=3 throughout. With ARB_TIMEOUT_EN there is still no preemption.
- ARB_TIMEOUT_EN, HOLD_MAX=8: requester 0 holds, and requester 2 asserts at cycle 3. The grant moves to 2 exactly 8 BUSY cycles after the grant to 0. Without the macro, 0 keeps the grant.
